// File: rtl/ffa_pkg.sv
// Shared definitions for the flip-flop array arbiter: default array geometry,
// the access kind driven onto the array, and the round-robin successor function.
package ffa_pkg;

  localparam int FFA_DATA_W = 8;
  localparam int FFA_ADDR_W = 3;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_WR   = 2'd1,
    ACC_RD   = 2'd2
  } ffa_acc_e;

  // Index that gets first priority after idx has been served, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ffa_rr_pick.sv
// Combinational rotate-priority picker: grants the first eligible index found
// searching upward from the pointer, wrapping modulo N. Grant is onehot0.
module ffa_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_elig,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic w_found;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    // Upper segment [ptr, N-1] first, then the wrapped segment [0, ptr-1].
    for (int j = 0; j < N; j++) begin
      if (!w_found && i_elig[j] && (j >= int'(i_ptr))) begin
        w_found    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IDX_W'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!w_found && i_elig[j] && (j < int'(i_ptr))) begin
        w_found    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IDX_W'(j);
      end
    end
  end

  assign o_any = w_found;

endmodule

// File: rtl/ffa_rr_arbiter.sv
// Round-robin arbiter sharing one single-port flip-flop register array between
// REQ_N requesters; one access per cycle, reads answered on a registered channel.
module ffa_rr_arbiter
  import ffa_pkg::*;
#(
  parameter int REQ_N  = 2,
  parameter int DATA_W = FFA_DATA_W,
  parameter int ADDR_W = FFA_ADDR_W,
  parameter int ID_W   = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [REQ_N-1:0]        i_req_valid,
  output logic [REQ_N-1:0]        o_req_ready,
  input  logic [REQ_N-1:0]        i_req_wr,
  input  logic [REQ_N*ADDR_W-1:0] i_req_addr,
  input  logic [REQ_N*DATA_W-1:0] i_req_din,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic [DATA_W-1:0]       o_rsp_data,
  output logic                    o_rsp_error,
  output logic [DATA_W-1:0]       o_ffa_din,
  output logic [ADDR_W-1:0]       o_ffa_addr,
  output logic                    o_ffa_wr,
  output logic                    o_ffa_rd,
  input  logic [DATA_W-1:0]       i_ffa_dout,
  input  logic                    i_ffa_error
);

  logic [ID_W-1:0]   r_ptr;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_error;

  logic              w_slot_free;
  logic [REQ_N-1:0]  w_elig;
  logic [REQ_N-1:0]  w_grant;
  logic [ID_W-1:0]   w_idx;
  logic              w_any;
  ffa_acc_e          w_acc;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_din;

  // Writes never need the response slot; reads need it empty or draining now.
  assign w_slot_free = ~r_rsp_valid | i_rsp_ready;
  assign w_elig      = resetn ? (i_req_valid & (i_req_wr | {REQ_N{w_slot_free}})) : '0;

  ffa_rr_pick #(
    .N     (REQ_N),
    .IDX_W (ID_W)
  ) u_pick (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Onehot grant mux: address, data and access kind of the winner, zeros when idle.
  always_comb begin
    w_acc  = ACC_IDLE;
    w_addr = '0;
    w_din  = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (w_grant[i]) begin
        w_addr = i_req_addr[i*ADDR_W +: ADDR_W];
        w_din  = i_req_din[i*DATA_W +: DATA_W];
        w_acc  = i_req_wr[i] ? ACC_WR : ACC_RD;
      end
    end
  end

  assign o_req_ready = w_grant;
  assign o_ffa_addr  = w_addr;
  assign o_ffa_din   = w_din;
  assign o_ffa_wr    = (w_acc == ACC_WR);
  assign o_ffa_rd    = (w_acc == ACC_RD);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= ID_W'(rr_next(32'(w_idx), REQ_N));
    end
  end

  // Array read data is combinational, so it is captured in the grant cycle itself.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
    end else if (o_ffa_rd) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_idx;
      r_rsp_data  <= i_ffa_dout;
      r_rsp_error <= i_ffa_error;
    end else if (i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_error = r_rsp_error;

endmodule
